// File: rtl/buffer_writer.sv
// Frame buffer ingress: packs RGB888 pixels into RAM words and writes whole frames
// into a rotating set of banks, always steering clear of the bank the reader holds.
module buffer_writer #(
   parameter int BLOCK_WIDTH = 32,
   parameter int BLOCK_DEPTH = 480,
   parameter int BANK_COUNT  = 3,
   parameter int BLOCK_COUNT = 4
) (
   input  logic                           I_clk,
   input  logic                           I_rst,
   input  logic                           I_vsync,
   input  logic                           I_de,
   input  logic [23:0]                    I_pixel,
   input  logic [$clog2(BANK_COUNT)-1:0]  I_read_bank,
   output logic                           O_wr_en,
   output logic [$clog2(BANK_COUNT)-1:0]  O_wr_bank,
   output logic [$clog2(BLOCK_COUNT)-1:0] O_wr_block,
   output logic [$clog2(BLOCK_DEPTH)-1:0] O_wr_addr,
   output logic [BLOCK_WIDTH-1:0]         O_wr_data,
   output logic                           O_frame_done,
   output logic [$clog2(BANK_COUNT)-1:0]  O_done_bank,
   output logic                           O_short_frame,
   output logic                           O_overflow
);

   localparam int BANK_W = $clog2(BANK_COUNT);
   localparam int BLK_W  = $clog2(BLOCK_COUNT);
   localparam int ADDR_W = $clog2(BLOCK_DEPTH);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BLOCK_DEPTH - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLOCK_COUNT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        state_r;
   logic              vs_q_r;
   logic              ovf_seen_r;
   logic [BANK_W-1:0] wbank_r;
   logic [BLK_W-1:0]  blk_r;
   logic [ADDR_W-1:0] addr_r;

   logic              vs_rise_s;
   logic              last_s;
   logic              started_s;
   logic [BLK_W-1:0]  blk_inc_s;
   logic [ADDR_W-1:0] addr_inc_s;
   logic [BANK_W-1:0] new_bank_s;

   // Lowest bank index that is neither the one just filled nor the reader's.
   function automatic logic [BANK_W-1:0] pick_bank(input logic [BANK_W-1:0] old_bank,
                                                   input logic [BANK_W-1:0] rd_bank);
      logic [BANK_W-1:0] sel;
      sel = {BANK_W{1'b0}};
      for (int b = BANK_COUNT - 1; b >= 0; b--) begin
         if ((BANK_W'(b) != old_bank) && (BANK_W'(b) != rd_bank)) begin
            sel = BANK_W'(b);
         end
      end
      return sel;
   endfunction

   // Edge detect, frame position decode and next counter values.
   always_comb begin
      vs_rise_s  = I_vsync & ~vs_q_r;
      last_s     = (blk_r == BLK_LAST) && (addr_r == ADDR_LAST);
      started_s  = (blk_r != {BLK_W{1'b0}}) || (addr_r != {ADDR_W{1'b0}});
      new_bank_s = pick_bank(wbank_r, I_read_bank);
      if (addr_r == ADDR_LAST) begin
         addr_inc_s = {ADDR_W{1'b0}};
         blk_inc_s  = blk_r + BLK_W'(1);
      end else begin
         addr_inc_s = addr_r + ADDR_W'(1);
         blk_inc_s  = blk_r;
      end
   end

   // Frame state machine with the registered write stage and status pulses.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_r       <= ST_IDLE;
         vs_q_r        <= 1'b1;
         ovf_seen_r    <= 1'b0;
         wbank_r       <= {BANK_W{1'b0}};
         blk_r         <= {BLK_W{1'b0}};
         addr_r        <= {ADDR_W{1'b0}};
         O_wr_en       <= 1'b0;
         O_wr_bank     <= {BANK_W{1'b0}};
         O_wr_block    <= {BLK_W{1'b0}};
         O_wr_addr     <= {ADDR_W{1'b0}};
         O_wr_data     <= {BLOCK_WIDTH{1'b0}};
         O_frame_done  <= 1'b0;
         O_done_bank   <= {BANK_W{1'b0}};
         O_short_frame <= 1'b0;
         O_overflow    <= 1'b0;
      end else begin
         vs_q_r        <= I_vsync;
         O_wr_en       <= 1'b0;
         O_frame_done  <= 1'b0;
         O_short_frame <= 1'b0;
         O_overflow    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (vs_rise_s) begin
                  state_r <= ST_WRITE;
                  blk_r   <= {BLK_W{1'b0}};
                  addr_r  <= {ADDR_W{1'b0}};
               end
            end
            ST_WRITE: begin
               if (I_de) begin
                  O_wr_en    <= 1'b1;
                  O_wr_bank  <= wbank_r;
                  O_wr_block <= blk_r;
                  O_wr_addr  <= addr_r;
                  O_wr_data  <= BLOCK_WIDTH'(I_pixel);
               end
               // A pixel arriving with the edge still belongs to the frame in progress.
               if (I_de && last_s) begin
                  O_frame_done <= 1'b1;
                  O_done_bank  <= wbank_r;
                  wbank_r      <= new_bank_s;
                  blk_r        <= {BLK_W{1'b0}};
                  addr_r       <= {ADDR_W{1'b0}};
                  ovf_seen_r   <= 1'b0;
                  state_r      <= vs_rise_s ? ST_WRITE : ST_FULL;
               end else if (vs_rise_s) begin
                  O_short_frame <= started_s | I_de;
                  blk_r         <= {BLK_W{1'b0}};
                  addr_r        <= {ADDR_W{1'b0}};
               end else if (I_de) begin
                  blk_r  <= blk_inc_s;
                  addr_r <= addr_inc_s;
               end
            end
            ST_FULL: begin
               if (I_de && !ovf_seen_r) begin
                  O_overflow <= 1'b1;
                  ovf_seen_r <= 1'b1;
               end
               if (vs_rise_s) begin
                  state_r <= ST_WRITE;
                  blk_r   <= {BLK_W{1'b0}};
                  addr_r  <= {ADDR_W{1'b0}};
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buffer_writer.sv
// Directed bench for buffer_writer: frame writes, bank rotation, short frames,
// overflow, DE gaps with a coincident VSYNC edge, and reset mid-frame.
module tb_buffer_writer;

   logic        clk;
   logic        I_rst;
   logic        I_vsync;
   logic        I_de;
   logic [23:0] I_pixel;
   logic [1:0]  I_read_bank;
   logic        O_wr_en;
   logic [1:0]  O_wr_bank;
   logic [1:0]  O_wr_block;
   logic [8:0]  O_wr_addr;
   logic [31:0] O_wr_data;
   logic        O_frame_done;
   logic [1:0]  O_done_bank;
   logic        O_short_frame;
   logic        O_overflow;

   int checks = 0;
   int errors = 0;

   // write monitor state: expected stream position and event tallies
   int         mon_writes, mon_bad, mon_idx;
   int         fd_count, fd_at_last, short_count, ovf_count;
   logic [1:0] fd_bank, mon_bank, mon_next;

   buffer_writer dut (
      .I_clk        (clk),
      .I_rst        (I_rst),
      .I_vsync      (I_vsync),
      .I_de         (I_de),
      .I_pixel      (I_pixel),
      .I_read_bank  (I_read_bank),
      .O_wr_en      (O_wr_en),
      .O_wr_bank    (O_wr_bank),
      .O_wr_block   (O_wr_block),
      .O_wr_addr    (O_wr_addr),
      .O_wr_data    (O_wr_data),
      .O_frame_done (O_frame_done),
      .O_done_bank  (O_done_bank),
      .O_short_frame(O_short_frame),
      .O_overflow   (O_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each write must land at block idx/480, addr idx%480 with data {0, A5, idx}.
   always @(negedge clk) begin
      if (O_wr_en) begin
         mon_writes++;
         if (O_wr_bank !== mon_bank || O_wr_block !== 2'(mon_idx / 480) ||
             O_wr_addr !== 9'(mon_idx % 480) ||
             O_wr_data !== (32'h00A5_0000 | 32'(mon_idx))) mon_bad++;
         mon_idx++;
      end
      if (O_frame_done) begin
         fd_count++;
         fd_bank = O_done_bank;
         if (O_wr_en && O_wr_block == 2'd3 && O_wr_addr == 9'd479) fd_at_last++;
         mon_idx  = 0;
         mon_bank = mon_next;
      end
      if (O_short_frame) begin
         short_count++;
         mon_idx = 0;
      end
      if (O_overflow) ovf_count++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon(input logic [1:0] bank, input logic [1:0] next);
      mon_writes = 0; mon_bad = 0; mon_idx = 0;
      fd_count = 0; fd_at_last = 0; short_count = 0; ovf_count = 0;
      fd_bank = 2'd0; mon_bank = bank; mon_next = next;
   endtask

   task automatic drive_pixel(input int idx);
      I_de    = 1'b1;
      I_pixel = 24'hA5_0000 | 24'(idx);
      step();
      I_de    = 1'b0;
   endtask

   task automatic vs_pulse();
      I_de = 1'b0; I_vsync = 1'b0;
      step();
      I_vsync = 1'b1;
      step();
      I_vsync = 1'b0;
   endtask

   task automatic run_frame(input int n);
      vs_pulse();
      for (int i = 0; i < n; i++) drive_pixel(i);
      step();
      step();
   endtask

   task automatic do_reset();
      I_rst = 1'b1; I_de = 1'b0; I_vsync = 1'b0;
      repeat (3) step();
      I_rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      I_rst = 1'b1; I_de = 1'b1; I_vsync = 1'b1; I_read_bank = 2'd2; I_pixel = 24'h123456;
      repeat (3) step();
      @(negedge clk);
      checks++;
      if ({O_wr_en, O_frame_done, O_short_frame, O_overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes got %b want 0000", {O_wr_en, O_frame_done, O_short_frame, O_overflow});
      end
      checks++;
      if ({O_wr_bank, O_wr_block, O_wr_addr, O_wr_data, O_done_bank} !== 47'd0) begin
         errors++;
         $display("FAIL reset_fields got %h want 0", {O_wr_bank, O_wr_block, O_wr_addr, O_wr_data, O_done_bank});
      end
      // VSYNC already high at release must not start a frame
      @(posedge clk); #1;
      I_rst = 1'b0;
      clear_mon(2'd0, 2'd1);
      repeat (6) step();
      checks++;
      if (mon_writes !== 0) begin
         errors++;
         $display("FAIL reset_vsync_high writes got %0d want 0", mon_writes);
      end
      I_de = 1'b0; I_vsync = 1'b0;
   endtask

   task automatic test_full_frame();
      do_reset();
      I_read_bank = 2'd2;
      clear_mon(2'd0, 2'd1);
      run_frame(1920);
      checks++;
      if (mon_writes !== 1920) begin
         errors++; $display("FAIL full_writes got %0d want 1920", mon_writes);
      end
      checks++;
      if (mon_bad !== 0) begin
         errors++; $display("FAIL full_content bad %0d want 0", mon_bad);
      end
      checks++;
      if (fd_count !== 1 || fd_bank !== 2'd0) begin
         errors++; $display("FAIL full_done count %0d bank %0d want 1 bank 0", fd_count, fd_bank);
      end
      checks++;
      if (fd_at_last !== 1) begin
         errors++; $display("FAIL full_done_timing got %0d want 1", fd_at_last);
      end
   endtask

   task automatic test_three_frames();
      logic [1:0] rd [3];
      logic [1:0] nx [3];
      rd[0] = 2'd2; rd[1] = 2'd0; rd[2] = 2'd1;
      nx[0] = 2'd1; nx[1] = 2'd2; nx[2] = 2'd0;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         I_read_bank = rd[f];
         clear_mon(2'(f), nx[f]);
         run_frame(1920);
         checks++;
         if (mon_writes !== 1920 || mon_bad !== 0 || fd_count !== 1 || fd_bank !== 2'(f)) begin
            errors++;
            $display("FAIL three_frames[%0d] writes %0d bad %0d done %0d bank %0d want 1920/0/1/%0d",
                     f, mon_writes, mon_bad, fd_count, fd_bank, f);
         end
      end
      clear_mon(2'd0, 2'd0);
      run_frame(3);
      checks++;
      if (mon_writes !== 3 || mon_bad !== 0) begin
         errors++; $display("FAIL three_frames_wrap writes %0d bad %0d want 3/0 in bank 0", mon_writes, mon_bad);
      end
   endtask

   task automatic test_short_frame();
      do_reset();
      I_read_bank = 2'd2;
      clear_mon(2'd0, 2'd1);
      run_frame(100);
      run_frame(1920);
      checks++;
      if (short_count !== 1) begin
         errors++; $display("FAIL short_pulse got %0d want 1", short_count);
      end
      checks++;
      if (fd_count !== 1 || fd_bank !== 2'd0) begin
         errors++; $display("FAIL short_done count %0d bank %0d want 1 bank 0", fd_count, fd_bank);
      end
      checks++;
      if (mon_writes !== 2020 || mon_bad !== 0) begin
         errors++; $display("FAIL short_writes got %0d bad %0d want 2020/0", mon_writes, mon_bad);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      I_read_bank = 2'd2;
      clear_mon(2'd0, 2'd1);
      vs_pulse();
      for (int i = 0; i < 1920; i++) drive_pixel(i);
      drive_pixel(1920);
      @(negedge clk);
      checks++;
      if (O_overflow !== 1'b1 || O_wr_en !== 1'b0) begin
         errors++; $display("FAIL ovf_timing ovf %b wr_en %b want 1/0", O_overflow, O_wr_en);
      end
      for (int i = 1921; i < 1925; i++) drive_pixel(i);
      step(); step();
      checks++;
      if (ovf_count !== 1) begin
         errors++; $display("FAIL ovf_count got %0d want 1", ovf_count);
      end
      checks++;
      if (mon_writes !== 1920 || mon_bad !== 0 || fd_count !== 1) begin
         errors++; $display("FAIL ovf_writes got %0d bad %0d done %0d want 1920/0/1", mon_writes, mon_bad, fd_count);
      end
   endtask

   task automatic test_gaps_coincident();
      int gaps;
      gaps = 0;
      do_reset();
      I_read_bank = 2'd2;
      clear_mon(2'd0, 2'd1);
      vs_pulse();
      for (int i = 0; i < 1919; i++) begin
         if (i % 7 == 3) begin
            I_de = 1'b0;
            step();
            gaps++;
         end
         drive_pixel(i);
      end
      I_vsync = 1'b1;
      drive_pixel(1919);
      I_vsync = 1'b0;
      for (int i = 0; i < 5; i++) begin
         I_de = 1'b0; step();
         drive_pixel(i);
      end
      step(); step();
      checks++;
      if (mon_writes !== 1925 || mon_bad !== 0) begin
         errors++; $display("FAIL gaps_writes got %0d bad %0d want 1925/0 (gaps %0d)", mon_writes, mon_bad, gaps);
      end
      checks++;
      if (fd_count !== 1 || fd_bank !== 2'd0 || short_count !== 0 || ovf_count !== 0) begin
         errors++;
         $display("FAIL gaps_events done %0d bank %0d short %0d ovf %0d want 1/0/0/0",
                  fd_count, fd_bank, short_count, ovf_count);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      I_read_bank = 2'd2;
      clear_mon(2'd0, 2'd1);
      run_frame(1920);
      clear_mon(2'd1, 2'd0);
      vs_pulse();
      for (int i = 0; i < 500; i++) drive_pixel(i);
      I_rst = 1'b1; I_vsync = 1'b1; I_de = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if ({O_wr_en, O_frame_done, O_short_frame, O_overflow, O_wr_bank, O_wr_block, O_wr_addr, O_wr_data}
          !== 49'd0) begin
         errors++; $display("FAIL midrst_outputs got nonzero (wr_en %b addr %0d)", O_wr_en, O_wr_addr);
      end
      checks++;
      if (mon_writes !== 500 || mon_bad !== 0) begin
         errors++; $display("FAIL midrst_prewrites got %0d bad %0d want 500/0", mon_writes, mon_bad);
      end
      @(posedge clk); #1;
      I_rst = 1'b0;
      clear_mon(2'd0, 2'd1);
      for (int i = 0; i < 10; i++) drive_pixel(i);
      step();
      checks++;
      if (mon_writes !== 0 || fd_count !== 0) begin
         errors++; $display("FAIL midrst_quiet writes %0d done %0d want 0/0", mon_writes, fd_count);
      end
      run_frame(10);
      checks++;
      if (mon_writes !== 10 || mon_bad !== 0) begin
         errors++; $display("FAIL midrst_restart writes %0d bad %0d want 10/0 in bank 0", mon_writes, mon_bad);
      end
   endtask

   initial begin
      I_rst = 1'b1; I_vsync = 1'b0; I_de = 1'b0; I_pixel = 24'd0; I_read_bank = 2'd2;
      clear_mon(2'd0, 2'd1);
      test_reset();
      test_full_frame();
      test_three_frames();
      test_short_frame();
      test_overflow();
      test_gaps_coincident();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
